// File: rtl/seq_scheduler.sv
// Streams a 32-bit word MSB-first into an external sequence detector,
// collecting its delayed match responses into a bitmap and hit count.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_valid/in_ready  word handshake; in_ready is high only in IDLE
//   in_data, in_len    pattern word and length (0 or >32 means 32)
//   abort              cancels a run in CLEAR, SHIFT or DRAIN
//   det_x, det_clr     serial bit and one-cycle clear to the detector
//   det_y              detector match response
//   busy, done         not-IDLE flag and one-cycle completion pulse
//   match_count/map    hit count and per-bit hit map of the last run
module seq_scheduler #(
  parameter int DET_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_len,
  input  logic        abort,
  output logic        det_x,
  output logic        det_clr,
  input  logic        det_y,
  output logic        busy,
  output logic        done,
  output logic [5:0]  match_count,
  output logic [31:0] match_map
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  localparam logic [5:0] LAT = 6'(DET_LATENCY);

  state_t      state;
  logic [31:0] data;
  logic [5:0]  len;
  logic [5:0]  pos;
  logic [5:0]  len_eff;
  logic [5:0]  idx;
  logic        hit;
  logic        last_shift;
  logic        last_drain;

  assign len_eff = (in_len == 6'd0 || in_len > 6'd32)
                 ? 6'd32 : in_len;

  // pos counts SHIFT/DRAIN cycles; the response seen now
  // belongs to the bit driven LAT cycles earlier.
  assign idx = pos - LAT;
  assign hit = (state == SHIFT || state == DRAIN)
            && (pos >= LAT) && (idx < len) && det_y;

  assign last_shift = (pos == len - 6'd1);
  assign last_drain = (pos == len + LAT - 6'd1);

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data        <= '0;
      len         <= '0;
      pos         <= '0;
      det_x       <= 1'b0;
      det_clr     <= 1'b0;
      match_count <= '0;
      match_map   <= '0;
    end else begin
      // Sampling still happens on an aborting edge, so partial
      // results include the response arriving in that cycle.
      if (hit) begin
        match_map[idx[4:0]] <= 1'b1;
        match_count         <= match_count + 6'd1;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data        <= in_data;
            len         <= len_eff;
            match_count <= '0;
            match_map   <= '0;
            det_clr     <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          det_clr <= 1'b0;
          pos     <= '0;
          if (abort) begin
            state <= IDLE;
          end else begin
            det_x <= data[31];
            data  <= data << 1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          pos <= pos + 6'd1;
          if (abort) begin
            det_x <= 1'b0;
            state <= IDLE;
          end else if (last_shift) begin
            det_x <= 1'b0;
            state <= (LAT == 6'd0) ? DONE : DRAIN;
          end else begin
            det_x <= data[31];
            data  <= data << 1;
          end
        end
        DRAIN: begin
          pos <= pos + 6'd1;
          if (abort) begin
            state <= IDLE;
          end else if (last_drain) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scheduler.sv
// Directed bench for seq_scheduler with a stub detector that
// echoes det_x one cycle later.
module tb_seq_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        abort;
  logic        det_x;
  logic        det_clr;
  logic        det_y;
  logic        busy;
  logic        done;
  logic [5:0]  match_count;
  logic [31:0] match_map;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stub detector: response = det_x delayed by one cycle.
  always_ff @(posedge clk) det_y <= det_x;

  seq_scheduler #(.DET_LATENCY(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_len      (in_len),
    .abort       (abort),
    .det_x       (det_x),
    .det_clr     (det_clr),
    .det_y       (det_y),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .match_map   (match_map)
  );

  // Accepts a word, then watches negedges k = 1.. after the
  // accepting edge; k is the cycle count after accept.
  task automatic run_watch(
    input  logic [31:0] d,
    input  logic [5:0]  l,
    input  int          leff,
    output int          done_at,
    output int          clr_cnt,
    output int          clr_at,
    output logic [31:0] xseq
  );
    @(negedge clk);
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
    @(posedge clk);
    done_at = 0;
    clr_cnt = 0;
    clr_at  = 0;
    xseq    = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (det_clr) begin
        clr_cnt++;
        clr_at = k;
      end
      if (k >= 2 && k < 2 + leff)
        xseq[33 - k] = det_x;
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    abort    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, busy, done, det_x, det_clr} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000",
               {in_ready, busy, done, det_x, det_clr});
    end
    checks++;
    if (match_count !== 6'd0 || match_map !== 32'd0) begin
      errors++;
      $display("FAIL reset_results got %0d/%h want 0/0",
               match_count, match_map);
    end
  endtask

  task automatic test_full_word();
    int da, cc, ca;
    logic [31:0] xs;
    run_watch(32'h4E525945, 6'd0, 32, da, cc, ca, xs);
    checks++;
    if (xs !== 32'h4E525945) begin
      errors++;
      $display("FAIL full_detx got %h want 4e525945", xs);
    end
    checks++;
    if (da !== 35) begin
      errors++;
      $display("FAIL full_done_at got %0d want 35", da);
    end
    checks++;
    if (match_count !== 6'd14) begin
      errors++;
      $display("FAIL full_count got %0d want 14", match_count);
    end
    checks++;
    if (match_map !== 32'hA29A4A72) begin
      errors++;
      $display("FAIL full_map got %h want a29a4a72", match_map);
    end
  endtask

  task automatic test_short();
    int da, cc, ca;
    logic [31:0] xs;
    run_watch(32'hF0000000, 6'd4, 4, da, cc, ca, xs);
    checks++;
    if (da !== 7) begin
      errors++;
      $display("FAIL short_done_at got %0d want 7", da);
    end
    checks++;
    if (cc !== 1 || ca !== 1) begin
      errors++;
      $display("FAIL short_clr got cnt=%0d at=%0d want 1/1", cc, ca);
    end
    checks++;
    if (xs !== 32'hF0000000) begin
      errors++;
      $display("FAIL short_detx got %h want f0000000", xs);
    end
    checks++;
    if (match_count !== 6'd4 || match_map !== 32'h0000000F) begin
      errors++;
      $display("FAIL short_result got %0d/%h want 4/0000000f",
               match_count, match_map);
    end
  endtask

  task automatic test_long_len();
    int da, cc, ca;
    logic [31:0] xs;
    run_watch(32'hFFFFFFFF, 6'd40, 32, da, cc, ca, xs);
    checks++;
    if (da !== 35) begin
      errors++;
      $display("FAIL long_done_at got %0d want 35", da);
    end
    checks++;
    if (match_count !== 6'd32 || match_map !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL long_result got %0d/%h want 32/ffffffff",
               match_count, match_map);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle got busy=%b ready=%b want 0/1",
               busy, in_ready);
    end
    checks++;
    if (match_count !== 6'd32 || match_map !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL hold_result got %0d/%h want 32/ffffffff",
               match_count, match_map);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    in_data  = 32'hFFFFFFFF;
    in_len   = 6'd32;
    in_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (done) seen++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || det_x !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b ready=%b x=%b want 0/1/0",
               busy, in_ready, det_x);
    end
    checks++;
    if (match_count !== 6'd5 || match_map !== 32'h0000001F) begin
      errors++;
      $display("FAIL abort_partial got %0d/%h want 5/0000001f",
               match_count, match_map);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    in_data  = 32'hA5A5A5A5;
    in_len   = 6'd32;
    in_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (done) seen++;
    end
    checks++;
    if (busy !== 1'b1 || match_count === 6'd0) begin
      errors++;
      $display("FAIL midrun_state got busy=%b cnt=%0d want 1/nonzero",
               busy, match_count);
    end
    reset = 1'b1;
    abort = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, done, det_x, det_clr} !== 5'b10000 ||
        match_count !== 6'd0 || match_map !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset got %b %0d %h want 10000 0 0",
               {in_ready, busy, done, det_x, det_clr},
               match_count, match_map);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] rdy_mask;
    logic [16:0] done_mask;
    rdy_mask  = '0;
    done_mask = '0;
    @(negedge clk);
    in_data  = 32'hF0000000;
    in_len   = 6'd4;
    in_valid = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k != 0) @(negedge clk);
      rdy_mask[k]  = in_ready;
      done_mask[k] = done;
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_mask !== 17'h10101) begin
      errors++;
      $display("FAIL b2b_ready got %h want 10101", rdy_mask);
    end
    checks++;
    if (done_mask !== 17'h08080) begin
      errors++;
      $display("FAIL b2b_done got %h want 08080", done_mask);
    end
    checks++;
    if (match_count !== 6'd4 || match_map !== 32'h0000000F) begin
      errors++;
      $display("FAIL b2b_result got %0d/%h want 4/0000000f",
               match_count, match_map);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short();
    test_long_len();
    test_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_scheduler.md
SEQ_SCHEDULER -- requirements
Module: seq_scheduler

Interface
REQ-001 The block SHALL have parameter DET_LATENCY, default 1, meaning the cycles from a bit on det_x to its det_y response (legal 0..3).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request to run a word through the detector.
REQ-005 in_ready  output  1  high only in IDLE; a word is accepted on a clk edge with in_valid && in_ready.
REQ-006 in_data  input  32  pattern word, streamed MSB (bit 31) first.
REQ-007 in_len  input  6  bits to stream; 0 or values >32 SHALL mean 32.
REQ-008 abort  input  1  cancel the run in progress.
REQ-009 det_x  output  1  serial bit to the sequence detector.
REQ-010 det_clr  output  1  one-cycle clear pulse to the detector's reset input.
REQ-011 det_y  input  1  detector match output.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when a run completes.
REQ-014 match_count  output  6  number of det_y hits in the last run.
REQ-015 match_map  output  32  bit j set when the response to streamed bit j was high.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, SHIFT, DRAIN and DONE.
REQ-017 On accept, the block SHALL latch in_data and the effective length L, clear match_count and match_map, and go to CLEAR.
REQ-018 CLEAR SHALL last 1 cycle with det_clr=1 and det_x=0, then go to SHIFT; det_clr SHALL be 0 in every other state.
REQ-019 SHIFT SHALL last L cycles, driving det_x = data[31-j] in SHIFT cycle j (j = 0..L-1).
REQ-020 det_y SHALL be sampled DET_LATENCY cycles after bit j is driven; if high, the block SHALL set match_map[j] and increment match_count.
REQ-021 Samples whose index j < 0 or j >= L SHALL be ignored.
REQ-022 DRAIN SHALL last DET_LATENCY cycles with det_x=0 while remaining samples are collected; DRAIN SHALL be skipped when DET_LATENCY=0.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-024 Run timing: done SHALL be high exactly 2+L+DET_LATENCY cycles after the accepting edge.
REQ-025 match_count and match_map SHALL hold their values from DONE until the next accept.
REQ-026 det_x SHALL be 0 in IDLE, CLEAR, DRAIN and DONE.
REQ-027 abort in CLEAR, SHIFT or DRAIN SHALL return the FSM to IDLE on the next edge without asserting done; partial results SHALL be retained.
REQ-028 abort in IDLE or DONE SHALL be ignored.
REQ-029 in_valid while busy SHALL be ignored (in_ready=0); the word is not queued.
REQ-030 match_count SHALL NOT wrap; it saturates naturally at 32 because L <= 32.

Reset
REQ-031 reset SHALL take priority over abort and in_valid on the same edge.
REQ-032 On reset: state=IDLE, in_ready=1, busy=0, done=0, det_x=0, det_clr=0, match_count=0, match_map=0.
REQ-033 reset asserted mid-run SHALL discard the run with no done pulse; the detector is cleared by the next run's CLEAR.

Verification (bench stub detector: det_y = det_x delayed DET_LATENCY cycles, DET_LATENCY=1)
REQ-034 Stimulus: in_data=0x4E525945, in_len=0. Required: det_x carries 0,1,0,0,1,1,1,0,... over 32 SHIFT cycles; done 35 cycles after accept; match_count=14; match_map=0xA29A4A72.
REQ-035 Stimulus: in_data=0xF0000000, in_len=4. Required: done 7 cycles after accept; match_count=4; match_map=0x0000000F; det_clr high exactly 1 cycle after accept.
REQ-036 Stimulus: in_data=0xFFFFFFFF, in_len=40. Required: treated as L=32; match_count=32; match_map=0xFFFFFFFF.
REQ-037 Stimulus: abort in SHIFT cycle 5 of a 0xFFFFFFFF/32 run. Required: IDLE next edge, done never asserted, match_count=5, in_ready=1.
REQ-038 Stimulus: reset in SHIFT cycle 10. Required: all outputs at REQ-032 values next cycle; no done pulse.
REQ-039 Stimulus: in_valid held high throughout a run. Required: exactly one accept per run; the next accept occurs on the first IDLE cycle after DONE.
